uart_msg_tx: RTL
================

Name: uart_msg_tx

Overview:
- Downstream consumer of the message unit's ASCII byte stream (FIM/BPM/BDM/END messages, each terminated by '#').
- Buffers bytes in a small FIFO and serialises them as 8N1 UART frames on a single TX line to the Bluetooth module.
- Accepts one byte per tx_valid pulse, with a ready/valid handshake.
- Decouples message composition timing from baud timing, so upstream no longer needs its per-byte hold counter.

Parameters:
- CLKS_PER_BIT, 434: clk_50M cycles per UART bit (50 MHz / 115200 baud, truncated).
- FIFO_DEPTH, 16: byte FIFO entries; must be a power of two.
- ADDR_W, 4: log2(FIFO_DEPTH).

Ports:
- clk_50M  input  1  system clock, 50 MHz; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_byte  input  8  byte to send (ASCII).
- tx_valid  input  1  single-cycle push strobe; tx_byte is sampled when tx_valid=1.
- tx_ready  output  1  1 when the FIFO is not full (registered count < FIFO_DEPTH).
- tx  output  1  UART serial line; idle high; registered.
- tx_busy  output  1  1 while the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  output  ADDR_W+1  current FIFO occupancy, range 0..FIFO_DEPTH.
- overflow  output  1  sticky flag: a push was attempted while full; cleared only by reset.

Behaviour:
- Reset (async assert, all outputs): tx=1, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0, FSM=IDLE, read/write pointers=0, baud counter=0, bit index=0.
- Reset mid-frame: tx returns high immediately; the partial frame and all buffered bytes are discarded.
- Push:
  - tx_valid && tx_ready at an edge writes tx_byte at wr_ptr; wr_ptr increments mod FIFO_DEPTH.
  - tx_valid && !tx_ready drops the byte, sets overflow=1, and leaves count and pointers unchanged.
- Pop: occurs only in IDLE when the registered count is nonzero. It loads the shift register from rd_ptr and increments rd_ptr mod FIFO_DEPTH.
- Simultaneous push and pop in one cycle: both occur; count is unchanged.
  - tx_ready depends only on the registered count. A push arriving when count=FIFO_DEPTH is dropped even if a pop happens in the same cycle.
- FSM states:
  - IDLE: tx=1. If count>0, pop and go to START; at that same edge tx<=0 and baud_cnt<=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles. When baud_cnt==CLKS_PER_BIT-1, go to DATA with bit_idx=0 and tx<=shift[0].
  - DATA: bits are sent LSB first, each held CLKS_PER_BIT cycles. At the end of bit 7, go to STOP with tx<=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: width is enough for CLKS_PER_BIT-1. It resets to 0 on each bit boundary and never free-runs in IDLE.
- Latency: a push into an empty FIFO while IDLE at edge n gives pop at edge n+1, so tx falls after edge n+1.
- Frame timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles of tx.
  - Back-to-back frames have exactly one IDLE cycle (tx=1) between the stop bit and the next start bit.
  - Frame period is therefore 10*CLKS_PER_BIT+1.
- Pointer wrap: pointers carry no extra wrap bit; full/empty are decided by fifo_count alone.
- tx_busy is combinational from the FSM state and count. It is 1 from the edge after the first push until the final STOP completes with the FIFO empty.

Decomposition:
- Shared package (msg_pkg): ASCII constants ('B','C','D','E','F','I','M','N','P','R','S','U','1'-'4','-','#'), CLK_FREQ=50_000_000, BAUD=115200, and the FSM state encoding (IDLE/START/DATA/STOP, 2 bits).
- One sub-module, byte_fifo: synchronous FIFO with FIFO_DEPTH×8 storage, push/pop, count, and async reset.
- The serialiser FSM stays in uart_msg_tx.

Test Plan:
- Single byte: CLKS_PER_BIT=434, push 0x42 ('B') at edge 0 → tx low from edge 1. Line sequence 0,0,1,0,0,0,0,1,0,1, each level held 434 cycles. tx_busy falls after 4341 cycles.
- Full message: push "FIM-ESU1-#" (10 bytes) on consecutive cycles.
  - → All accepted, overflow=0.
  - → 10 frames decoded in order by the bench UART monitor, each 4341 cycles apart.
  - → fifo_count peaks at 9.
- Overflow, with CLKS_PER_BIT=8: 18 consecutive pushes from idle.
  - → First 17 accepted: one popped at edge 1, 16 stored.
  - → 18th dropped; overflow=1 and stays 1 until reset.
  - → 17 frames emitted.
- Simultaneous push/pop: fill the FIFO to 3, then push exactly on the IDLE pop edge → fifo_count stays 3, and byte order is preserved.
- Wrap-around: send 40 bytes 0x00..0x27 in bursts of 12 with CLKS_PER_BIT=8 → all 40 received in order, with no loss across pointer wrap.
- Reset mid-frame: assert reset during DATA bit 3 with 5 bytes queued.
  - → tx=1 asynchronously; fifo_count=0, overflow=0.
  - → No further frames after release until a new push.

Source files
------------

// File: rtl/msg_pkg.sv
// msg_pkg: ASCII constants, clock/baud settings and serialiser state encoding shared by the message datapath.
package msg_pkg;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD = 115200;
  localparam logic [7:0] ASCII_B = 8'h42;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_D = 8'h44;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_F = 8'h46;
  localparam logic [7:0] ASCII_I = 8'h49;
  localparam logic [7:0] ASCII_M = 8'h4D;
  localparam logic [7:0] ASCII_N = 8'h4E;
  localparam logic [7:0] ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_U = 8'h55;
  localparam logic [7:0] ASCII_1 = 8'h31;
  localparam logic [7:0] ASCII_2 = 8'h32;
  localparam logic [7:0] ASCII_3 = 8'h33;
  localparam logic [7:0] ASCII_4 = 8'h34;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; full/empty come from count alone, so pointers carry no wrap bit.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [ADDR_W:0]   count
);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk_50M or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end
  always_ff @(posedge clk_50M)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: buffers message bytes and serialises them as 8N1 UART frames on tx.
module uart_msg_tx import msg_pkg::*; #(
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [7:0]        tx_byte,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);
  localparam int CNT_W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  tx_state_t state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, fifo_dout;
  logic push, pop, bit_done;
  assign tx_ready = fifo_count != (ADDR_W+1)'(FIFO_DEPTH);
  assign push = tx_valid && tx_ready;
  assign pop = state == IDLE && fifo_count != '0;
  assign tx_busy = state != IDLE || fifo_count != '0;
  assign bit_done = baud_cnt == CNT_W'(CLKS_PER_BIT - 1);
  byte_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk_50M(clk_50M),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(tx_byte),
    .dout(fifo_dout),
    .count(fifo_count)
  );
  // shift holds the remaining data bits; tx always shows the bit currently on the line
  always_ff @(posedge clk_50M or posedge reset)
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      baud_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      overflow <= 1'b0;
    end else begin
      if (tx_valid && !tx_ready) overflow <= 1'b1;
      case (state)
        IDLE:
          if (pop) begin
            state <= START;
            shift <= fifo_dout;
            tx <= 1'b0;
            baud_cnt <= '0;
          end
        START:
          if (bit_done) begin
            state <= DATA;
            bit_idx <= '0;
            tx <= shift[0];
            baud_cnt <= '0;
          end else baud_cnt <= baud_cnt + 1'b1;
        DATA:
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift <= {1'b0, shift[7:1]};
              tx <= shift[1];
            end
          end else baud_cnt <= baud_cnt + 1'b1;
        STOP:
          if (bit_done) begin
            state <= IDLE;
            baud_cnt <= '0;
          end else baud_cnt <= baud_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
